logic_pod_burst_arbiter: RTL and testbench
==========================================

LOGIC_POD_BURST_ARBITER -- requirements
Module: logic_pod_burst_arbiter

Interface
REQ-001 Parameter NUM_CHANNELS, default 8: capture channels arbitrated (power of 2, 2..16).
REQ-002 Parameter DATA_WIDTH, default 128: channel FIFO and output data width.
REQ-003 Parameter BURST_LEN, default 4: words per burst (power of 2, 2..16).
REQ-004 Parameter PTR_WIDTH, default 22: per-channel DRAM burst pointer width.
REQ-005 Parameter POD_NUMBER, default 0: pod index; bit 0 is placed in the address.
REQ-006 Port clk_ram_2x, input, 1: sole clock. One clock; reset is asynchronous and active-low.
REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
REQ-008 Ports fifo_rd_en (output, NUM_CHANNELS) and fifo_rd_data (input, NUM_CHANNELS x DATA_WIDTH): channel FIFO pop; data is valid 1 cycle after rd_en.
REQ-009 Ports fifo_half_full and fifo_burst_ready, input, NUM_CHANNELS: urgency flag, and a flag meaning at least BURST_LEN words are present.
REQ-010 Ports data_fifo_wr_en (output, 1), data_fifo_wr_data (output, DATA_WIDTH) and data_fifo_wr_size (input, 10): output data FIFO write port and its free-slot count.
REQ-011 Ports addr_fifo_wr_en (output, 1), addr_fifo_wr_data (output, ADDR_WIDTH) and addr_fifo_wr_size (input, 8): address FIFO write port and its free-slot count.
REQ-012 Port ptr_wrapped, output, NUM_CHANNELS: sticky flag set when a channel's pointer wraps to 0.

Function
REQ-013 ADDR_WIDTH SHALL be 2 + clog2(NUM_CHANNELS) + PTR_WIDTH + clog2(BURST_LEN); the address word is {1'b1, POD_NUMBER[0], channel, ptr[channel], zeros}.
REQ-014 FSM states: IDLE, GRANT, BURST. IDLE goes to GRANT when a grant is found; GRANT goes to BURST on the next cycle; BURST returns to IDLE after BURST_LEN pops.
REQ-015 Grant evaluation is gated: data_fifo_wr_size >= 2*BURST_LEN and addr_fifo_wr_size >= 2. If the gate is not met, no grant is issued and the state is held.
REQ-016 Priority order: (1) round-robin among fifo_half_full channels, starting after the last grant; (2) continue the last channel if its burst_ready is set; (3) round-robin among burst_ready channels.
REQ-017 fifo_rd_en is one-hot on the granted channel for exactly BURST_LEN consecutive cycles, starting the cycle after the grant. It is never asserted for a channel whose burst_ready was low at grant.
REQ-018 A new grant SHALL be evaluated during the final BURST_LEN-1 cycle, so that bursts run back-to-back with zero idle cycles.
REQ-019 data_fifo_wr_en SHALL assert exactly 2 cycles after each fifo_rd_en cycle, carrying that word. Word order within a burst is preserved.
REQ-020 addr_fifo_wr_en SHALL pulse exactly once per burst, in the cycle of the burst's first fifo_rd_en. The pointer increments by 1 in that same cycle.
REQ-021 A pointer at all-ones SHALL wrap to 0 and set ptr_wrapped for that channel. The flag stays set until reset.
REQ-022 If burst_ready drops mid-burst, the burst SHALL still complete (the upstream guarantee is honoured).

Reset
REQ-023 On rst_n low, asynchronously: FSM to IDLE, all pointers 0, round-robin index 0, ptr_wrapped 0, and all outputs (rd_en, wr_en, wr_data, addr) 0.
REQ-024 Reset mid-burst SHALL abort the burst and discard in-flight pipeline words; no partial write is issued after deassertion.

Configuration
REQ-025 The macro LOGIC_POD_ARB_STATS_EN SHALL control burst statistics.
- Defined: per-channel 32-bit saturating burst counters plus a 32-bit counter of gate-stalled cycles, exposed as output ports burst_count[NUM_CHANNELS] and stall_count.
- Undefined: these ports and registers are absent; no other behaviour changes.

Structure
REQ-026 Package logic_pod_pkg SHALL hold the FSM state enum, default parameter constants, and the address-field layout widths.
REQ-027 Round-robin selection SHALL live in a sub-module rr_priority_select (request vector and start index in, one-hot grant and valid out, combinational), instantiated twice.

Verification
REQ-028 Channel 3 only, burst_ready=1 -> 4 pops; address {1,0,3,0,00}, then pointer increments to 1; 4 data words out 2 cycles after each pop, in order.
REQ-029 Channels 1 and 5 half_full, last grant 5 -> grant 1 then 5, alternating; no gaps between bursts.
REQ-030 Channel 2 continuing and channel 6 half_full -> channel 6 wins.
REQ-031 data_fifo_wr_size=7 with BURST_LEN=4 -> no grant; raise to 8 -> grant on the next evaluation.
REQ-032 PTR_WIDTH=2, 5 bursts on channel 0 -> pointers 0,1,2,3,0; ptr_wrapped[0] set after the 4th.
REQ-033 rst_n low at the 2nd pop of a burst -> all outputs 0 at once; no data_fifo_wr_en afterwards until a new grant.

Source files
------------

// File: rtl/logic_pod_pkg.sv
// Shared types and constants for the logic-pod burst arbiter: FSM states,
// default parameters and the DRAM address-field layout.
package logic_pod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BURST = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_CHANNELS = 8;
  localparam int DEF_DATA_WIDTH   = 128;
  localparam int DEF_BURST_LEN    = 4;
  localparam int DEF_PTR_WIDTH    = 22;
  localparam int DEF_POD_NUMBER   = 0;

  // Address layout, MSB first: {1'b1, pod bit, channel, pointer, word-in-burst zeros}
  localparam int ADDR_TAG_W  = 2;
  localparam int DATA_SIZE_W = 10;
  localparam int ADDR_SIZE_W = 8;
  localparam int STAT_W      = 32;

  function automatic int calc_addr_width(input int num_channels, input int ptr_width,
                                         input int burst_len);
    return ADDR_TAG_W + $clog2(num_channels) + ptr_width + $clog2(burst_len);
  endfunction

endpackage

// File: rtl/logic_pod_burst_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after 'start',
// wrapping around; returns a one-hot grant.
module rr_priority_select #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic          valid
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] gnt_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   gnt_rot;

  // Rotate so 'start' lands on bit 0, isolate the lowest set bit, rotate back.
  assign req_dbl = {req, req} >> start;
  assign req_rot = req_dbl[N-1:0];
  assign gnt_rot = req_rot & (~req_rot + N'(1));
  assign gnt_dbl = {gnt_rot, gnt_rot} << start;
  assign grant   = gnt_dbl[2*N-1:N];
  assign valid   = |req;

endmodule

// File: rtl/logic_pod_burst_arbiter.sv
// Burst arbiter moving capture-channel FIFO bursts into the shared DRAM data/address FIFOs.
// Optional LOGIC_POD_ARB_STATS_EN adds per-channel burst counters and a gate-stall counter.
module logic_pod_burst_arbiter
  import logic_pod_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int BURST_LEN    = DEF_BURST_LEN,
  parameter int PTR_WIDTH    = DEF_PTR_WIDTH,
  parameter int POD_NUMBER   = DEF_POD_NUMBER,
  parameter int ADDR_WIDTH   = calc_addr_width(NUM_CHANNELS, PTR_WIDTH, BURST_LEN)
) (
  input  logic                               clk_ram_2x,
  input  logic                               rst_n,
  output logic [NUM_CHANNELS-1:0]            fifo_rd_en,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] fifo_rd_data,
  input  logic [NUM_CHANNELS-1:0]            fifo_half_full,
  input  logic [NUM_CHANNELS-1:0]            fifo_burst_ready,
  output logic                               data_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]              data_fifo_wr_data,
  input  logic [DATA_SIZE_W-1:0]             data_fifo_wr_size,
  output logic                               addr_fifo_wr_en,
  output logic [ADDR_WIDTH-1:0]              addr_fifo_wr_data,
  input  logic [ADDR_SIZE_W-1:0]             addr_fifo_wr_size,
  output logic [NUM_CHANNELS-1:0]            ptr_wrapped
`ifdef LOGIC_POD_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]                  burst_count [NUM_CHANNELS],
  output logic [STAT_W-1:0]                  stall_count
`endif
);

  localparam int CH_W   = $clog2(NUM_CHANNELS);
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;
  localparam int ZERO_W = $clog2(BURST_LEN);
  localparam logic POD_BIT = 1'(POD_NUMBER & 1);

  arb_state_e              state_reg;
  logic [BEAT_W-1:0]       beat_reg;
  logic [CH_W-1:0]         cur_ch_reg;
  logic                    last_valid_reg;
  logic [CH_W-1:0]         rr_idx_reg;
  logic [PTR_WIDTH-1:0]    ptr_reg [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] rd_en_reg;
  logic [NUM_CHANNELS-1:0] wrapped_reg;
  logic                    awr_en_reg;
  logic [ADDR_WIDTH-1:0]   awr_data_reg;
  logic                    pipe_vld_reg;
  logic [CH_W-1:0]         pipe_ch_reg;
  logic                    dwr_en_reg;
  logic [DATA_WIDTH-1:0]   dwr_data_reg;

  logic [DATA_WIDTH-1:0]   rd_word [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] urgent_req, hf_gnt, br_gnt;
  logic                    hf_vld, br_vld, continue_ok, gate_ok, eval_point, do_grant;
  logic [CH_W-1:0]         hf_idx, br_idx, grant_ch;

  genvar gi;
  for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_unpack
    assign rd_word[gi] = fifo_rd_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Urgent requests only count when a full burst is actually available.
  assign urgent_req = fifo_half_full & fifo_burst_ready;

  rr_priority_select #(.N(NUM_CHANNELS)) u_rr_urgent (
    .req(urgent_req), .start(rr_idx_reg), .grant(hf_gnt), .valid(hf_vld)
  );

  rr_priority_select #(.N(NUM_CHANNELS)) u_rr_ready (
    .req(fifo_burst_ready), .start(rr_idx_reg), .grant(br_gnt), .valid(br_vld)
  );

  always_comb begin
    hf_idx = '0;
    br_idx = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (hf_gnt[i]) hf_idx = CH_W'(i);
      if (br_gnt[i]) br_idx = CH_W'(i);
    end
  end

  assign continue_ok = last_valid_reg && fifo_burst_ready[cur_ch_reg];
  assign grant_ch    = hf_vld ? hf_idx : (continue_ok ? cur_ch_reg : br_idx);
  assign gate_ok     = (data_fifo_wr_size >= DATA_SIZE_W'(2*BURST_LEN)) &&
                       (addr_fifo_wr_size >= ADDR_SIZE_W'(2));
  // The last beat of a burst is also an evaluation point so bursts can chain.
  assign eval_point  = (state_reg == ST_IDLE) ||
                       (state_reg == ST_BURST && beat_reg == BEAT_W'(BURST_LEN));
  assign do_grant    = eval_point && gate_ok && (hf_vld || continue_ok || br_vld);

  always_ff @(posedge clk_ram_2x or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      beat_reg       <= '0;
      cur_ch_reg     <= '0;
      last_valid_reg <= 1'b0;
      rr_idx_reg     <= '0;
      rd_en_reg      <= '0;
      wrapped_reg    <= '0;
      awr_en_reg     <= 1'b0;
      awr_data_reg   <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) ptr_reg[i] <= '0;
    end else begin
      awr_en_reg <= 1'b0;
      if (do_grant) begin
        state_reg         <= ST_GRANT;
        beat_reg          <= BEAT_W'(1);
        cur_ch_reg        <= grant_ch;
        last_valid_reg    <= 1'b1;
        rr_idx_reg        <= grant_ch + CH_W'(1);
        rd_en_reg         <= NUM_CHANNELS'(1) << grant_ch;
        awr_en_reg        <= 1'b1;
        awr_data_reg      <= {1'b1, POD_BIT, grant_ch, ptr_reg[grant_ch], {ZERO_W{1'b0}}};
        ptr_reg[grant_ch] <= ptr_reg[grant_ch] + PTR_WIDTH'(1);
        if (&ptr_reg[grant_ch]) wrapped_reg[grant_ch] <= 1'b1;
      end else begin
        case (state_reg)
          ST_GRANT: begin
            state_reg <= ST_BURST;
            beat_reg  <= beat_reg + BEAT_W'(1);
          end
          ST_BURST: begin
            if (beat_reg == BEAT_W'(BURST_LEN)) begin
              state_reg <= ST_IDLE;
              rd_en_reg <= '0;
            end else begin
              beat_reg <= beat_reg + BEAT_W'(1);
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  // FIFO data arrives one cycle after the pop; register it once more on the way out.
  always_ff @(posedge clk_ram_2x or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_reg <= 1'b0;
      pipe_ch_reg  <= '0;
      dwr_en_reg   <= 1'b0;
      dwr_data_reg <= '0;
    end else begin
      pipe_vld_reg <= |rd_en_reg;
      pipe_ch_reg  <= cur_ch_reg;
      dwr_en_reg   <= pipe_vld_reg;
      if (pipe_vld_reg) dwr_data_reg <= rd_word[pipe_ch_reg];
    end
  end

  assign fifo_rd_en        = rd_en_reg;
  assign data_fifo_wr_en   = dwr_en_reg;
  assign data_fifo_wr_data = dwr_data_reg;
  assign addr_fifo_wr_en   = awr_en_reg;
  assign addr_fifo_wr_data = awr_data_reg;
  assign ptr_wrapped       = wrapped_reg;

`ifdef LOGIC_POD_ARB_STATS_EN
  for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_stat
    always_ff @(posedge clk_ram_2x or negedge rst_n) begin
      if (!rst_n) burst_count[gi] <= '0;
      else if (do_grant && grant_ch == CH_W'(gi) && burst_count[gi] != '1)
        burst_count[gi] <= burst_count[gi] + STAT_W'(1);
    end
  end

  // A stall is an evaluation point with work pending but no room downstream.
  always_ff @(posedge clk_ram_2x or negedge rst_n) begin
    if (!rst_n) stall_count <= '0;
    else if (eval_point && !gate_ok && (|fifo_burst_ready) && stall_count != '1)
      stall_count <= stall_count + STAT_W'(1);
  end
`endif

endmodule

// File: tb/tb_logic_pod_burst_arbiter.sv
// Directed bench for logic_pod_burst_arbiter: records per-cycle output traces
// and compares them with hand-computed expectations, one task per scenario.
module tb_logic_pod_burst_arbiter;
  localparam int NCH = 8;
  localparam int DW  = 16;
  localparam int BL  = 4;
  localparam int PW  = 2;
  localparam int AW  = 9;

  logic              clk_ram_2x = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    fifo_rd_en;
  logic [NCH*DW-1:0] fifo_rd_data;
  logic [NCH-1:0]    fifo_half_full = '0;
  logic [NCH-1:0]    fifo_burst_ready = '0;
  logic              data_fifo_wr_en;
  logic [DW-1:0]     data_fifo_wr_data;
  logic [9:0]        data_fifo_wr_size = 10'd512;
  logic              addr_fifo_wr_en;
  logic [AW-1:0]     addr_fifo_wr_data;
  logic [7:0]        addr_fifo_wr_size = 8'd16;
  logic [NCH-1:0]    ptr_wrapped;
`ifdef LOGIC_POD_ARB_STATS_EN
  logic [31:0]       burst_count [NCH];
  logic [31:0]       stall_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [NCH-1:0] tr_rd [64];
  logic           tr_aw [64];
  logic [AW-1:0]  tr_ad [64];
  logic           tr_dw [64];
  logic [DW-1:0]  tr_dd [64];
  logic [NCH-1:0] tr_pw [64];
  int             tn;
  logic [7:0]     pcnt [NCH];

  always #5 clk_ram_2x = ~clk_ram_2x;

  logic_pod_burst_arbiter #(
    .NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .BURST_LEN(BL), .PTR_WIDTH(PW), .POD_NUMBER(0)
  ) dut (
    .clk_ram_2x(clk_ram_2x), .rst_n(rst_n),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_half_full(fifo_half_full), .fifo_burst_ready(fifo_burst_ready),
    .data_fifo_wr_en(data_fifo_wr_en), .data_fifo_wr_data(data_fifo_wr_data),
    .data_fifo_wr_size(data_fifo_wr_size),
    .addr_fifo_wr_en(addr_fifo_wr_en), .addr_fifo_wr_data(addr_fifo_wr_data),
    .addr_fifo_wr_size(addr_fifo_wr_size),
    .ptr_wrapped(ptr_wrapped)
`ifdef LOGIC_POD_ARB_STATS_EN
    , .burst_count(burst_count), .stall_count(stall_count)
`endif
  );

  // Channel FIFO model: each pop presents {channel, sequence number} one cycle later.
  always @(posedge clk_ram_2x or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) pcnt[c] <= 8'd0;
      fifo_rd_data <= '0;
    end else begin
      for (int c = 0; c < NCH; c++)
        if (fifo_rd_en[c]) begin
          fifo_rd_data[c*DW +: DW] <= {8'(c), pcnt[c]};
          pcnt[c] <= pcnt[c] + 8'd1;
        end
    end
  end

  task automatic cyc();
    @(negedge clk_ram_2x);
    tr_rd[tn] = fifo_rd_en;
    tr_aw[tn] = addr_fifo_wr_en;
    tr_ad[tn] = addr_fifo_wr_data;
    tr_dw[tn] = data_fifo_wr_en;
    tr_dd[tn] = data_fifo_wr_data;
    tr_pw[tn] = ptr_wrapped;
    $display("[TB] t=%0d rd_en=%h aw=%0d addr=%h dw=%0d data=%h wrapped=%h",
             tn, fifo_rd_en, addr_fifo_wr_en, addr_fifo_wr_data,
             data_fifo_wr_en, data_fifo_wr_data, ptr_wrapped);
    tn++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fifo_half_full = '0;
    fifo_burst_ready = '0;
    data_fifo_wr_size = 10'd512;
    addr_fifo_wr_size = 8'd16;
    repeat (2) @(negedge clk_ram_2x);
    rst_n = 1'b1;
    @(negedge clk_ram_2x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({fifo_rd_en, addr_fifo_wr_en, data_fifo_wr_en} !== '0) begin
      $display("FAIL reset_enables got rd=%h aw=%b dw=%b exp all 0",
               fifo_rd_en, addr_fifo_wr_en, data_fifo_wr_en);
      n_fail++;
    end
    n_tests++;
    if ({addr_fifo_wr_data, data_fifo_wr_data, ptr_wrapped} !== '0) begin
      $display("FAIL reset_data got addr=%h data=%h wrapped=%h exp all 0",
               addr_fifo_wr_data, data_fifo_wr_data, ptr_wrapped);
      n_fail++;
    end
    do_reset();
  endtask

  task automatic test_single_channel();
    logic [NCH-1:0] er;
    logic [DW-1:0]  ed;
    do_reset();
    fifo_burst_ready = 8'h08;
    tn = 0;
    cyc();
    fifo_burst_ready = 8'h00;
    repeat (7) cyc();
    for (int t = 0; t < 8; t++) begin
      er = (t < 4) ? 8'h08 : 8'h00;
      n_tests++;
      if (tr_rd[t] !== er) begin
        $display("FAIL single_rd_en t=%0d got %h exp %h", t, tr_rd[t], er); n_fail++;
      end
      n_tests++;
      if (tr_aw[t] !== (t == 0)) begin
        $display("FAIL single_addr_wr t=%0d got %b exp %b", t, tr_aw[t], t == 0); n_fail++;
      end
      n_tests++;
      if (tr_dw[t] !== (t >= 2 && t <= 5)) begin
        $display("FAIL single_data_wr t=%0d got %b exp %b", t, tr_dw[t], t >= 2 && t <= 5);
        n_fail++;
      end
      if (t >= 2 && t <= 5) begin
        ed = {8'd3, 8'(t - 2)};
        n_tests++;
        if (tr_dd[t] !== ed) begin
          $display("FAIL single_data t=%0d got %h exp %h", t, tr_dd[t], ed); n_fail++;
        end
      end
    end
    n_tests++;
    if (tr_ad[0] !== 9'h130) begin
      $display("FAIL single_addr0 got %h exp 130", tr_ad[0]); n_fail++;
    end
    fifo_burst_ready = 8'h08;
    tn = 0;
    cyc();
    fifo_burst_ready = 8'h00;
    repeat (6) cyc();
    n_tests++;
    if (tr_aw[0] !== 1'b1 || tr_ad[0] !== 9'h134) begin
      $display("FAIL single_addr1 got aw=%b addr=%h exp aw=1 addr=134", tr_aw[0], tr_ad[0]);
      n_fail++;
    end
    for (int t = 2; t < 6; t++) begin
      ed = {8'd3, 8'(t + 2)};
      n_tests++;
      if (tr_dw[t] !== 1'b1 || tr_dd[t] !== ed) begin
        $display("FAIL single_data2 t=%0d got dw=%b %h exp dw=1 %h", t, tr_dw[t], tr_dd[t], ed);
        n_fail++;
      end
    end
  endtask

  task automatic test_rr_half_full();
    logic [NCH-1:0] er;
    logic [AW-1:0]  ea [4];
    ea[0] = 9'h150; ea[1] = 9'h110; ea[2] = 9'h154; ea[3] = 9'h114;
    do_reset();
    fifo_half_full = 8'h20;
    fifo_burst_ready = 8'h20;
    tn = 0;
    cyc();
    fifo_half_full = 8'h22;
    fifo_burst_ready = 8'h22;
    repeat (15) cyc();
    fifo_half_full = 8'h00;
    fifo_burst_ready = 8'h00;
    repeat (4) cyc();
    for (int t = 0; t < 20; t++) begin
      er = (t >= 16) ? 8'h00 : (((t / 4) % 2 == 0) ? 8'h20 : 8'h02);
      n_tests++;
      if (tr_rd[t] !== er) begin
        $display("FAIL rr_rd_en t=%0d got %h exp %h", t, tr_rd[t], er); n_fail++;
      end
      n_tests++;
      if (tr_aw[t] !== (t % 4 == 0 && t < 16)) begin
        $display("FAIL rr_addr_wr t=%0d got %b exp %b", t, tr_aw[t], t % 4 == 0 && t < 16);
        n_fail++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (tr_ad[4*k] !== ea[k]) begin
        $display("FAIL rr_addr burst=%0d got %h exp %h", k, tr_ad[4*k], ea[k]); n_fail++;
      end
    end
  endtask

  task automatic test_priority();
    logic [NCH-1:0] er;
    do_reset();
    fifo_burst_ready = 8'h04;
    tn = 0;
    cyc();
    fifo_burst_ready = 8'h0C;
    repeat (4) cyc();
    fifo_half_full = 8'h40;
    fifo_burst_ready = 8'h4C;
    repeat (4) cyc();
    fifo_half_full = 8'h00;
    fifo_burst_ready = 8'h00;
    repeat (5) cyc();
    for (int t = 0; t < 14; t++) begin
      er = (t < 8) ? 8'h04 : ((t < 12) ? 8'h40 : 8'h00);
      n_tests++;
      if (tr_rd[t] !== er) begin
        $display("FAIL prio_rd_en t=%0d got %h exp %h", t, tr_rd[t], er); n_fail++;
      end
    end
    n_tests++;
    if (tr_ad[8] !== 9'h160) begin
      $display("FAIL prio_addr got %h exp 160", tr_ad[8]); n_fail++;
    end
  endtask

  task automatic test_gate();
    logic [NCH-1:0] er;
    do_reset();
    data_fifo_wr_size = 10'd7;
    fifo_burst_ready = 8'h01;
    tn = 0;
    repeat (4) cyc();
    data_fifo_wr_size = 10'd8;
    cyc();
    fifo_burst_ready = 8'h00;
    repeat (4) cyc();
    addr_fifo_wr_size = 8'd1;
    fifo_burst_ready = 8'h01;
    repeat (3) cyc();
    addr_fifo_wr_size = 8'd2;
    cyc();
    fifo_burst_ready = 8'h00;
    repeat (6) cyc();
    for (int t = 0; t < 19; t++) begin
      er = ((t >= 4 && t < 8) || (t >= 12 && t < 16)) ? 8'h01 : 8'h00;
      n_tests++;
      if (tr_rd[t] !== er) begin
        $display("FAIL gate_rd_en t=%0d got %h exp %h", t, tr_rd[t], er); n_fail++;
      end
      n_tests++;
      if (tr_aw[t] !== (t == 4 || t == 12)) begin
        $display("FAIL gate_addr_wr t=%0d got %b exp %b", t, tr_aw[t], t == 4 || t == 12);
        n_fail++;
      end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea;
    do_reset();
    fifo_burst_ready = 8'h01;
    tn = 0;
    repeat (17) cyc();
    fifo_burst_ready = 8'h00;
    repeat (5) cyc();
    for (int k = 0; k < 5; k++) begin
      ea = 9'h100 | 9'((k % 4) << 2);
      n_tests++;
      if (tr_aw[4*k] !== 1'b1 || tr_ad[4*k] !== ea) begin
        $display("FAIL wrap_addr burst=%0d got aw=%b %h exp aw=1 %h", k, tr_aw[4*k], tr_ad[4*k], ea);
        n_fail++;
      end
    end
    n_tests++;
    if (tr_pw[11] !== 8'h00) begin
      $display("FAIL wrap_flag_before got %h exp 00", tr_pw[11]); n_fail++;
    end
    n_tests++;
    if (tr_pw[12] !== 8'h01) begin
      $display("FAIL wrap_flag_set got %h exp 01", tr_pw[12]); n_fail++;
    end
    n_tests++;
    if (tr_pw[21] !== 8'h01) begin
      $display("FAIL wrap_flag_sticky got %h exp 01", tr_pw[21]); n_fail++;
    end
    n_tests++;
    if (tr_rd[19] !== 8'h01 || tr_rd[20] !== 8'h00) begin
      $display("FAIL wrap_end got rd19=%h rd20=%h exp 01 00", tr_rd[19], tr_rd[20]); n_fail++;
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    fifo_burst_ready = 8'h10;
    tn = 0;
    cyc();
    fifo_burst_ready = 8'h00;
    cyc();
    n_tests++;
    if (tr_rd[1] !== 8'h10) begin
      $display("FAIL midrst_pre got rd=%h exp 10", tr_rd[1]); n_fail++;
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({fifo_rd_en, addr_fifo_wr_en, data_fifo_wr_en, addr_fifo_wr_data, data_fifo_wr_data} !== '0) begin
      $display("FAIL midrst_async got rd=%h aw=%b dw=%b addr=%h data=%h exp all 0",
               fifo_rd_en, addr_fifo_wr_en, data_fifo_wr_en, addr_fifo_wr_data, data_fifo_wr_data);
      n_fail++;
    end
    @(negedge clk_ram_2x);
    rst_n = 1'b1;
    tn = 0;
    repeat (6) cyc();
    for (int t = 0; t < 6; t++) begin
      n_tests++;
      if ({tr_rd[t], tr_aw[t], tr_dw[t]} !== '0) begin
        $display("FAIL midrst_quiet t=%0d got rd=%h aw=%b dw=%b exp 0", t, tr_rd[t], tr_aw[t], tr_dw[t]);
        n_fail++;
      end
    end
    fifo_burst_ready = 8'h10;
    tn = 0;
    cyc();
    fifo_burst_ready = 8'h00;
    repeat (6) cyc();
    n_tests++;
    if (tr_aw[0] !== 1'b1 || tr_ad[0] !== 9'h140) begin
      $display("FAIL midrst_regrant got aw=%b addr=%h exp aw=1 addr=140", tr_aw[0], tr_ad[0]);
      n_fail++;
    end
    n_tests++;
    if (tr_dw[2] !== 1'b1 || tr_dd[2] !== 16'h0400) begin
      $display("FAIL midrst_data got dw=%b %h exp dw=1 0400", tr_dw[2], tr_dd[2]); n_fail++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    tn = 0;
    test_reset();
    test_single_channel();
    test_rr_half_full();
    test_priority();
    test_gate();
    test_wrap();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
